alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, clocked successor of the team's 8-bit combinational ALU.
- Same 16-entry command map, at generic operand width.
- Registered results and status flags, with a start/busy/done handshake.
- Iterative multi-cycle multiply and divide (divide returns quotient and remainder).
- Drives a shared tri-state result bus under output-enable control.

Parameters:
WIDTH, 8, operand width in bits (>=2); result width is 2*WIDTH
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset: synchronous, active-low
a_in  input  WIDTH  operand A (unsigned; signed view used for overflow only)
b_in  input  WIDTH  operand B
command_in  input  4  opcode, sampled with start_in
start_in  input  1  request; accepted on an edge where start_in=1 and state=IDLE
oe  input  1  output enable for d_out
d_out  output  2*WIDTH  result register when oe=1, else all-Z
busy_out  output  1  high while state=RUN
done_out  output  1  one-cycle pulse when a new result/flags are written
flags_out  output  4  {dz, v, c, z}: div-by-zero, signed overflow, carry/borrow, zero

Behaviour:
- Reset: synchronous, active-low, sampled each rising edge.
  - state=IDLE; result=0; flags=0; done_out=0; busy_out=0; counter=0.
  - Reset during RUN aborts the operation; no done pulse; result/flags forced to 0.
- Opcodes: 0 ADD, 1 INC, 2 SUB, 3 DEC, 4 MUL, 5 DIV, 6 SHL, 7 SHR, 8 AND, 9 OR, A INV, B NAND, C NOR, D XOR, E XNOR, F BUF.
- States: IDLE, RUN.
  - start_in sampled only in IDLE; ignored while busy (no queueing).
  - Operands and opcode are latched at acceptance; input changes afterwards have no effect.
- Single-cycle ops (all except MUL, and DIV with b!=0):
  - Accepted at edge k; result/flags written at edge k.
  - done_out=1 for the cycle following edge k; state stays IDLE.
  - Back-to-back starts give one result per cycle.
- MUL: shift-add, one partial product per cycle.
  - Accept at edge k -> RUN; iterations at edges k+1..k+WIDTH.
  - Result written at edge k+WIDTH; done_out high in the following cycle; busy_out high after edge k until edge k+WIDTH.
  - Result is the full 2*WIDTH unsigned product.
- DIV: restoring divide, same timing as MUL.
  - d[WIDTH-1:0] = quotient; d[2W-1:W] = remainder.
  - If b=0: no RUN; single-cycle completion; result=0, dz=1.
- Width rules (W=WIDTH). Upper bits not listed below are 0.
  - ADD/INC (INC uses b=1): d[W:0] = a+b. c = d[W]. v = signed overflow.
  - SUB/DEC (DEC uses b=1): d[W-1:0] = a-b mod 2^W. c = borrow (a<b), also placed in d[W]. v = signed overflow.
  - SHL: d[W:0] = {a,1'b0}; c = a[W-1].
  - SHR: d[W-1:0] = a>>1; c = a[0].
  - Logic ops: d[W-1:0] = bitwise result; c = v = 0.
  - MUL/DIV: c = v = 0.
  - BUF: d[W-1:0] = a.
- Flags:
  - z = (full 2W result == 0). dz = 0 except DIV with b=0.
  - Flags update together with the result; both hold until the next completion.
- oe is purely combinational on d_out. done_out and flags_out are never tri-stated.

Test Plan:
- W=8, reset low 2 edges -> d_out=0, flags=0, busy=0, done=0; with oe=0, d_out=16'hZZZZ.
- ADD a=8'hFF, b=8'h01 -> next cycle done=1, d=16'h0100, c=1, z=0.
- ADD a=8'h7F, b=8'h01 -> v=1.
- SUB a=3, b=5 -> d=16'h01FE, c=1.
- MUL a=8'hFF, b=8'hFF -> busy 8 cycles, done 8 cycles after acceptance, d=16'hFE01.
  - A start_in pulse during busy is ignored.
- DIV a=100, b=7 -> d=16'h020E (rem 2, quot 14), dz=0.
- DIV a=5, b=0 -> single-cycle, d=0, dz=1, z=1.
- MUL started, rst_n low at iteration 4 -> no done pulse, d=0, IDLE.
- Next ADD completes normally.
- Repeat ADD/MUL/DIV checks at WIDTH=16 against a reference model.

Source files
------------

// File: rtl/alu_seq.sv
// Clocked 16-op ALU with start/busy/done handshake, iterative MUL/DIV and a
// tri-state result bus. Results and flags are registered and held until the next completion.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic [3:0]         command_in,
    input  logic               start_in,
    input  logic               oe,
    output logic [2*WIDTH-1:0] d_out,
    output logic               busy_out,
    output logic               done_out,
    output logic [3:0]         flags_out
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'h0, OP_INC = 4'h1, OP_SUB = 4'h2, OP_DEC = 4'h3,
                           OP_MUL = 4'h4, OP_DIV = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
                           OP_AND = 4'h8, OP_OR  = 4'h9, OP_INV = 4'hA, OP_NAND = 4'hB,
                           OP_NOR = 4'hC, OP_XOR = 4'hD, OP_XNOR = 4'hE, OP_BUF = 4'hF;

    typedef enum logic [0:0] {IDLE, RUN} state_t;
    state_t state, state_nx;

    logic [2*WIDTH-1:0] result;
    logic [3:0]         flags;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi, lo, opnd;
    logic               is_div;

    logic               accept, launch, finish;
    logic [WIDTH-1:0]   bb;
    logic [WIDTH:0]     add_w, sub_w;
    logic [2*WIDTH-1:0] op_res;
    logic               op_c, op_v, op_dz;
    logic [WIDTH:0]     mul_sum, div_sh, div_sub;
    logic               div_ge;
    logic [WIDTH-1:0]   hi_nx, lo_nx;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        launch   = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: if (start_in) begin
                accept = 1'b1;
                if (command_in == OP_MUL || (command_in == OP_DIV && b_in != '0)) begin
                    launch   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: if (cnt == LAST) begin
                finish   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Single-cycle datapath, evaluated straight from the inputs at the accepting edge
    always_comb begin
        op_res = '0;
        op_c   = 1'b0;
        op_v   = 1'b0;
        op_dz  = 1'b0;
        bb     = (command_in == OP_INC || command_in == OP_DEC) ? WIDTH'(1) : b_in;
        add_w  = {1'b0, a_in} + {1'b0, bb};
        sub_w  = {1'b0, a_in} - {1'b0, bb};
        case (command_in)
            OP_ADD, OP_INC: begin
                op_res[WIDTH:0] = add_w;
                op_c = add_w[WIDTH];
                op_v = (a_in[WIDTH-1] == bb[WIDTH-1]) && (add_w[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_SUB, OP_DEC: begin
                op_res[WIDTH:0] = sub_w;
                op_c = sub_w[WIDTH];
                op_v = (a_in[WIDTH-1] != bb[WIDTH-1]) && (sub_w[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_SHL: begin
                op_res[WIDTH:0] = {a_in, 1'b0};
                op_c = a_in[WIDTH-1];
            end
            OP_SHR: begin
                op_res[WIDTH-1:0] = a_in >> 1;
                op_c = a_in[0];
            end
            OP_AND:  op_res[WIDTH-1:0] = a_in & b_in;
            OP_OR:   op_res[WIDTH-1:0] = a_in | b_in;
            OP_INV:  op_res[WIDTH-1:0] = ~a_in;
            OP_NAND: op_res[WIDTH-1:0] = ~(a_in & b_in);
            OP_NOR:  op_res[WIDTH-1:0] = ~(a_in | b_in);
            OP_XOR:  op_res[WIDTH-1:0] = a_in ^ b_in;
            OP_XNOR: op_res[WIDTH-1:0] = ~(a_in ^ b_in);
            OP_BUF:  op_res[WIDTH-1:0] = a_in;
            OP_DIV:  op_dz = 1'b1;  // only reached here when b == 0
            default: op_res = '0;
        endcase
    end

    // One shift-add (MUL) or restoring-subtract (DIV) step on {hi, lo}
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_sh  = {hi, lo[WIDTH-1]};
        div_ge  = div_sh >= {1'b0, opnd};
        div_sub = div_sh - {1'b0, opnd};
        if (is_div) begin
            hi_nx = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
            lo_nx = {lo[WIDTH-2:0], div_ge};
        end else begin
            hi_nx = mul_sum[WIDTH:1];
            lo_nx = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            result   <= '0;
            flags    <= '0;
            done_out <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
        end else begin
            state    <= state_nx;
            done_out <= 1'b0;
            if (launch) begin
                hi     <= '0;
                lo     <= (command_in == OP_DIV) ? a_in : b_in;
                opnd   <= (command_in == OP_DIV) ? b_in : a_in;
                is_div <= (command_in == OP_DIV);
                cnt    <= '0;
            end else if (accept) begin
                result   <= op_res;
                flags    <= {op_dz, op_v, op_c, op_res == '0};
                done_out <= 1'b1;
            end
            if (state == RUN) begin
                hi  <= hi_nx;
                lo  <= lo_nx;
                cnt <= cnt + 1'b1;
                if (finish) begin
                    result   <= {hi_nx, lo_nx};
                    flags    <= {3'b000, {hi_nx, lo_nx} == '0};
                    done_out <= 1'b1;
                    cnt      <= '0;
                end
            end
        end
    end

    assign busy_out  = (state == RUN);
    assign flags_out = flags;
    assign d_out     = oe ? result : 'z;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: fixed vectors and corner sequences at WIDTH=8, random ops
// against an arithmetic reference model at WIDTH=8 and WIDTH=16.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  a8, b8;
    logic [3:0]  cmd8;
    logic        start8, oe8, busy8, done8;
    logic [3:0]  flags8;
    wire  [15:0] d8;
    logic [15:0] a16, b16;
    logic [3:0]  cmd16;
    logic        start16, oe16, busy16, done16;
    logic [3:0]  flags16;
    wire  [31:0] d16;

    alu_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .a_in(a8), .b_in(b8), .command_in(cmd8),
        .start_in(start8), .oe(oe8), .d_out(d8), .busy_out(busy8),
        .done_out(done8), .flags_out(flags8));
    alu_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .a_in(a16), .b_in(b16), .command_in(cmd16),
        .start_in(start16), .oe(oe16), .d_out(d16), .busy_out(busy16),
        .done_out(done16), .flags_out(flags16));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: results from the opcode rules with plain integer arithmetic.
    function automatic void model(input int w, input logic [3:0] op,
                                  input longint unsigned a, input longint unsigned b,
                                  output longint unsigned d, output logic [3:0] f);
        longint unsigned m, bb;
        longint sa, sb, s;
        logic c, v, dz;
        m  = (64'd1 << w) - 1;
        bb = (op == 4'h1 || op == 4'h3) ? 1 : b;
        sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = bb[w-1] ? longint'(bb) - (longint'(1) << w) : longint'(bb);
        c = 0; v = 0; dz = 0; d = 0;
        case (op)
            4'h0, 4'h1: begin
                d = a + bb; c = d[w]; s = sa + sb;
                v = (s > (longint'(1) << (w-1)) - 1) || (s < -(longint'(1) << (w-1)));
            end
            4'h2, 4'h3: begin
                c = a < bb; d = ((a - bb) & m) | (longint'(c) << w); s = sa - sb;
                v = (s > (longint'(1) << (w-1)) - 1) || (s < -(longint'(1) << (w-1)));
            end
            4'h4: d = a * bb;
            4'h5: if (bb == 0) dz = 1; else d = ((a % bb) << w) | (a / bb);
            4'h6: begin d = a << 1; c = a[w-1]; end
            4'h7: begin d = a >> 1; c = a[0]; end
            4'h8: d = a & bb;
            4'h9: d = a | bb;
            4'hA: d = ~a & m;
            4'hB: d = ~(a & bb) & m;
            4'hC: d = ~(a | bb) & m;
            4'hD: d = a ^ bb;
            4'hE: d = ~(a ^ bb) & m;
            default: d = a;
        endcase
        f = {dz, v, c, d == 0};
    endfunction

    // Issue one op; lat = edges after acceptance until done seen, bsy = cycles busy seen.
    task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int poke_at, output logic [15:0] d, output logic [3:0] f,
                        output int lat, output int bsy);
        @(negedge clk);
        cmd8 = op; a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~a; b8 = ~b; cmd8 = ~op;
        lat = 0; bsy = 0;
        while (!done8 && lat < 100) begin
            if (busy8) bsy++;
            start8 = (lat == poke_at);
            @(posedge clk); #1;
            start8 = 1'b0;
            lat++;
        end
        if (!done8) chk("timeout8", 64'(lat), 64'(-1));
        d = d8; f = flags8;
    endtask

    task automatic run16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] d, output logic [3:0] f, output int lat);
        @(negedge clk);
        cmd16 = op; a16 = a; b16 = b; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0; a16 = ~a; b16 = ~b;
        lat = 0;
        while (!done16 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done16) chk("timeout16", 64'(lat), 64'(-1));
        d = d16; f = flags16;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a, b;
        logic [15:0] d;
        logic [3:0]  f;
        int          lat;
    } vec_t;
    vec_t vt[11];

    initial begin
        logic [15:0] d;
        logic [31:0] dw;
        logic [3:0]  f;
        int          lat, bsy;
        logic        saw_done;
        longint unsigned md;
        logic [3:0]  mf;

        vt[0]  = '{4'h0, 8'hFF, 8'h01, 16'h0100, 4'b0010, 0};
        vt[1]  = '{4'h0, 8'h7F, 8'h01, 16'h0080, 4'b0100, 0};
        vt[2]  = '{4'h2, 8'h03, 8'h05, 16'h01FE, 4'b0010, 0};
        vt[3]  = '{4'h4, 8'hFF, 8'hFF, 16'hFE01, 4'b0000, 8};
        vt[4]  = '{4'h5, 8'd100, 8'd7, 16'h020E, 4'b0000, 8};
        vt[5]  = '{4'h5, 8'h05, 8'h00, 16'h0000, 4'b1001, 0};
        vt[6]  = '{4'h3, 8'h00, 8'h3C, 16'h01FF, 4'b0010, 0};
        vt[7]  = '{4'h1, 8'hFF, 8'h3C, 16'h0100, 4'b0010, 0};
        vt[8]  = '{4'h6, 8'h80, 8'h00, 16'h0100, 4'b0010, 0};
        vt[9]  = '{4'h7, 8'h01, 8'h00, 16'h0000, 4'b0011, 0};
        vt[10] = '{4'hE, 8'hAA, 8'h55, 16'h0000, 4'b0001, 0};

        a8 = '0; b8 = '0; cmd8 = '0; start8 = 1'b0; oe8 = 1'b1;
        a16 = '0; b16 = '0; cmd16 = '0; start16 = 1'b0; oe16 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_d", 64'(d8), 64'h0);
        chk("reset_flags", 64'(flags8), 64'h0);
        chk("reset_busy", 64'(busy8), 64'h0);
        chk("reset_done", 64'(done8), 64'h0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            run8(vt[i].op, vt[i].a, vt[i].b, -1, d, f, lat, bsy);
            chk($sformatf("vec%0d_d", i), 64'(d), 64'(vt[i].d));
            chk($sformatf("vec%0d_flags", i), 64'(f), 64'(vt[i].f));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].lat));
            chk($sformatf("vec%0d_busy", i), 64'(bsy), 64'(vt[i].lat));
        end

        // Output enable off: bus must stop driving the held result
        run8(4'h0, 8'hFF, 8'h01, -1, d, f, lat, bsy);
        oe8 = 1'b0; #1;
        checks++;
        if (d8 === 16'h0100) begin
            errors++;
            $display("FAIL oe_off: got %h expected not driven", d8);
        end
        oe8 = 1'b1; #1;

        // Start pulse during MUL must be dropped, not queued
        run8(4'h4, 8'hFF, 8'hFF, 3, d, f, lat, bsy);
        chk("mul_poke_d", 64'(d), 64'hFE01);
        chk("mul_poke_lat", 64'(lat), 64'd8);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done8), 64'h0);
        chk("held_d", 64'(d8), 64'hFE01);

        // Reset at iteration 4 aborts MUL
        @(negedge clk);
        cmd8 = 4'h4; a8 = 8'h13; b8 = 8'h27; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        saw_done = 1'b0;
        repeat (3) begin @(posedge clk); #1; saw_done |= done8; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 64'(busy8), 64'h0);
        chk("abort_d", 64'(d8), 64'h0);
        chk("abort_flags", 64'(flags8), 64'h0);
        rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; saw_done |= done8; end
        chk("abort_no_done", 64'(saw_done), 64'h0);
        run8(4'h0, 8'h12, 8'h34, -1, d, f, lat, bsy);
        chk("post_abort_add", 64'(d), 64'h0046);
        chk("post_abort_lat", 64'(lat), 64'h0);

        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            logic [7:0] ra, rb;
            op = 4'($urandom_range(0, 15));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            model(8, op, 64'(ra), 64'(rb), md, mf);
            run8(op, ra, rb, -1, d, f, lat, bsy);
            chk($sformatf("rnd8_%0d_op%0h_d", i, op), 64'(d), md);
            chk($sformatf("rnd8_%0d_op%0h_flags", i, op), 64'(f), 64'(mf));
            chk($sformatf("rnd8_%0d_op%0h_lat", i, op), 64'(lat),
                (op == 4'h4 || (op == 4'h5 && rb != 0)) ? 64'd8 : 64'd0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [15:0] ra, rb;
            case ($urandom_range(0, 2))
                0: op = 4'h0;
                1: op = 4'h4;
                default: op = 4'h5;
            endcase
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom >> $urandom_range(0, 12));
            model(16, op, 64'(ra), 64'(rb), md, mf);
            run16(op, ra, rb, dw, f, lat);
            chk($sformatf("rnd16_%0d_op%0h_d", i, op), 64'(dw), md);
            chk($sformatf("rnd16_%0d_op%0h_flags", i, op), 64'(f), 64'(mf));
            chk($sformatf("rnd16_%0d_op%0h_lat", i, op), 64'(lat),
                (op == 4'h4 || (op == 4'h5 && rb != 0)) ? 64'd16 : 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
